// File: rtl/des_key_sched.sv
// DES key-schedule controller: PC-1 on load, per-round C/D rotation, PC-2 subkey
// presented over a valid/ready handshake in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:64] key_in,
    input  logic        key_load,
    input  logic        decrypt,
    output logic        key_ready,
    output logic [48:1] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);
    // state | meaning
    // IDLE  | waiting for key_load; key_ready high
    // GEN   | presenting subkey for `round`; advance on handshake
    typedef enum logic {IDLE, GEN} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    state_t      state;
    logic        mode_dec;
    logic [27:0] c_q, d_q;
    logic [55:0] pc1_v;
    logic [55:0] cd;
    logic [4:0]  enc_idx, dec_idx;
    logic        two_enc, two_dec;

    // Internal vectors are descending: FIPS bit p lives at index (width - p).
    function automatic logic ls_is_two(input logic [4:0] n);
        return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    always_comb begin
        pc1_v = '0;
        for (int i = 0; i < 56; i++) pc1_v[55-i] = key_in[PC1[i]];
    end

    assign cd = {c_q, d_q};

    always_comb begin
        subkey = '0;
        for (int i = 0; i < 48; i++) subkey[48-i] = cd[56-PC2[i]];
    end

    // Shift amount for the step out of the current round, indexed by pre-increment round.
    assign enc_idx = {1'b0, round} + 5'd2;
    assign dec_idx = 5'd16 - {1'b0, round};
    assign two_enc = ls_is_two(enc_idx);
    assign two_dec = ls_is_two(dec_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mode_dec     <= 1'b0;
            c_q          <= '0;
            d_q          <= '0;
            round        <= '0;
            key_ready    <= 1'b1;
            subkey_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_load) begin
                        mode_dec     <= decrypt;
                        c_q          <= decrypt ? pc1_v[55:28] : rotl(pc1_v[55:28], 1'b0);
                        d_q          <= decrypt ? pc1_v[27:0]  : rotl(pc1_v[27:0], 1'b0);
                        round        <= '0;
                        state        <= GEN;
                        key_ready    <= 1'b0;
                        subkey_valid <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                GEN: begin
                    if (subkey_ready) begin
                        if (round == 4'd15) begin
                            state        <= IDLE;
                            round        <= '0;
                            done         <= 1'b1;
                            key_ready    <= 1'b1;
                            subkey_valid <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            round <= round + 4'd1;
                            c_q   <= mode_dec ? rotr(c_q, two_dec) : rotl(c_q, two_enc);
                            d_q   <= mode_dec ? rotr(d_q, two_dec) : rotl(d_q, two_enc);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: scoreboard of expected subkeys built from
// an independent cumulative-shift model, compared on each handshake.
module tb_des_key_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        key_load;
    logic        decrypt;
    logic        key_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    des_key_sched dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .decrypt(decrypt),
        .key_ready(key_ready), .subkey(subkey), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .round(round), .busy(busy), .done(done));

    always #5 clk = ~clk;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int LSV [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PARITY = 64'h0101010101010101;

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] cap [16];
    logic [47:0] enc_cap [16];
    int          total = 0;
    int          bad = 0;

    // Kn computed directly from C0D0 rotated left by the cumulative shift count.
    function automatic logic [47:0] ref_k(input logic [63:0] k, input int n);
        logic [55:0] cd0, cdn;
        logic [27:0] c, d;
        logic [47:0] r;
        int s;
        for (int i = 0; i < 56; i++) cd0[55-i] = k[64-PC1[i]];
        s = 0;
        for (int j = 0; j < n; j++) s += LSV[j];
        c = cd0[55:28];
        d = cd0[27:0];
        for (int j = 0; j < 28; j++) begin
            cdn[55-j] = c[27-((j+s)%28)];
            cdn[27-j] = d[27-((j+s)%28)];
        end
        for (int i = 0; i < 48; i++) r[47-i] = cdn[56-PC2[i]];
        return r;
    endfunction

    task automatic load_key(input logic [63:0] k, input logic dec);
        exp_t e;
        total++;
        if (key_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_ready: key_ready=%b want 1", key_ready);
        end
        key_in = k;
        decrypt = dec;
        key_load = 1'b1;
        for (int r = 0; r < 16; r++) begin
            e.sk = ref_k(k, dec ? 16 - r : r + 1);
            e.rd = r[3:0];
            exp_q.push_back(e);
        end
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Consume the queued schedule; ends on the negedge of the done cycle.
    task automatic drain(input bit rnd, input bit glitch, input logic [63:0] gkey);
        exp_t        e;
        logic [47:0] last_sk = '0;
        logic [3:0]  last_rd = '0;
        bit          stalled = 0;
        int          hs = 0;
        int          budget = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            total++;
            if (subkey_valid !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL gen_valid: valid=%b busy=%b want 1 1", subkey_valid, busy);
            end
            if (stalled) begin
                total++;
                if (subkey !== last_sk || round !== last_rd) begin
                    bad++;
                    $display("FAIL stall_hold: subkey=%h round=%0d want %h %0d",
                             subkey, round, last_sk, last_rd);
                end
            end
            key_load = glitch && (hs == 5 || hs == 6);
            if (glitch) begin
                key_in = gkey;
                decrypt = ~decrypt;
            end
            subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (subkey_ready && subkey_valid) begin
                e = exp_q.pop_front();
                total++;
                if (subkey !== e.sk || round !== e.rd) begin
                    bad++;
                    $display("FAIL subkey: got %h round %0d want %h round %0d",
                             subkey, round, e.sk, e.rd);
                end
                cap[e.rd] = subkey;
                hs++;
            end
            stalled = !subkey_ready;
            last_sk = subkey;
            last_rd = round;
            @(negedge clk);
            budget++;
        end
        key_load = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d subkeys outstanding want 0", exp_q.size());
            exp_q.delete();
        end
        total++;
        if (done !== 1'b1 || key_ready !== 1'b1 || busy !== 1'b0 || subkey_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_cycle: done=%b ready=%b busy=%b valid=%b want 1 1 0 0",
                     done, key_ready, busy, subkey_valid);
        end
    endtask

    task automatic check_done_low();
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b want 0", done);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (key_ready !== 1'b1 || busy !== 1'b0 || subkey_valid !== 1'b0 ||
            done !== 1'b0 || round !== 4'd0 || subkey !== 48'd0) begin
            bad++;
            $display("FAIL %s: ready=%b busy=%b valid=%b done=%b round=%0d subkey=%h want 1 0 0 0 0 0",
                     tag, key_ready, busy, subkey_valid, done, round, subkey);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_load = 1'b1;
        key_in = KEY_A;
        decrypt = 1'b0;
        subkey_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        key_load = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_encrypt();
        load_key(KEY_A, 1'b0);
        drain(0, 0, '0);
        total++;
        if (cap[0] !== 48'h1B02EFFC7072) begin
            bad++; $display("FAIL enc_k1: got %h want 1b02effc7072", cap[0]);
        end
        total++;
        if (cap[1] !== 48'h79AED9DBC9E5) begin
            bad++; $display("FAIL enc_k2: got %h want 79aed9dbc9e5", cap[1]);
        end
        total++;
        if (cap[15] !== 48'hCB3D8B0E17F5) begin
            bad++; $display("FAIL enc_k16: got %h want cb3d8b0e17f5", cap[15]);
        end
        for (int i = 0; i < 16; i++) enc_cap[i] = cap[i];
        check_done_low();
    endtask

    task automatic test_decrypt();
        load_key(KEY_A, 1'b1);
        drain(0, 0, '0);
        total++;
        if (cap[0] !== 48'hCB3D8B0E17F5 || cap[15] !== 48'h1B02EFFC7072) begin
            bad++;
            $display("FAIL dec_ends: got %h %h want cb3d8b0e17f5 1b02effc7072", cap[0], cap[15]);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (cap[i] !== enc_cap[15-i]) begin
                bad++; $display("FAIL dec_reverse[%0d]: got %h want %h", i, cap[i], enc_cap[15-i]);
            end
        end
        check_done_low();
    endtask

    task automatic test_backpressure();
        load_key(KEY_A, 1'b0);
        drain(1, 0, '0);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (cap[i] !== enc_cap[i]) begin
                bad++; $display("FAIL bp_seq[%0d]: got %h want %h", i, cap[i], enc_cap[i]);
            end
        end
        check_done_low();
    endtask

    task automatic test_midgen_load();
        load_key(KEY_A, 1'b0);
        drain(1, 1, KEY_B);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (cap[i] !== enc_cap[i]) begin
                bad++; $display("FAIL midgen_seq[%0d]: got %h want %h", i, cap[i], enc_cap[i]);
            end
        end
        check_done_low();
    endtask

    task automatic test_back_to_back();
        load_key(KEY_B, 1'b0);
        drain(0, 0, '0);
        load_key(KEY_A, 1'b1);
        total++;
        if (done !== 1'b0 || subkey !== 48'hCB3D8B0E17F5 || round !== 4'd0) begin
            bad++;
            $display("FAIL b2b_first: done=%b subkey=%h round=%0d want 0 cb3d8b0e17f5 0",
                     done, subkey, round);
        end
        drain(0, 0, '0);
        check_done_low();
    endtask

    task automatic test_rst_mid();
        exp_t e;
        int   guard = 0;
        load_key(KEY_B, 1'b0);
        subkey_ready = 1'b1;
        while (round != 4'd7 && guard < 40) begin
            e = exp_q.pop_front();
            total++;
            if (subkey !== e.sk || round !== e.rd) begin
                bad++;
                $display("FAIL rst_pre: got %h round %0d want %h round %0d", subkey, round, e.sk, e.rd);
            end
            @(negedge clk);
            guard++;
        end
        total++;
        if (round !== 4'd7) begin
            bad++; $display("FAIL rst_reach7: round=%0d want 7", round);
        end
        subkey_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check_reset_outputs("rst_mid");
        load_key(KEY_A, 1'b0);
        drain(0, 0, '0);
        check_done_low();
    endtask

    task automatic test_parity();
        load_key(KEY_A ^ PARITY, 1'b0);
        drain(1, 0, '0);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (cap[i] !== enc_cap[i]) begin
                bad++; $display("FAIL parity[%0d]: got %h want %h", i, cap[i], enc_cap[i]);
            end
        end
        check_done_low();
    endtask

    initial begin
        rst = 1'b1;
        key_load = 1'b0;
        key_in = '0;
        decrypt = 1'b0;
        subkey_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_midgen_load();
        test_back_to_back();
        test_rst_mid();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/des_key_sched.md
# des_key_sched

Sequential DES key-schedule controller. It accepts a 64-bit key, applies PC-1, then steps the 28-bit C/D halves through the 16-round rotation schedule. Each round it presents one 48-bit PC-2 subkey to the round datapath over a valid/ready handshake. It supports encrypt order (K1..K16) and decrypt order (K16..K1) and sits between the key register and the DES round engine.

## Interface
Parameters:
- none (DES widths fixed: 64-bit key, 56-bit CD, 48-bit subkey)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- key_in  in  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,…,64 ignored
- key_load  in  1  request to start a schedule with key_in
- decrypt  in  1  sampled with key_load; 1 = emit K16..K1
- key_ready  out  1  high in IDLE only; key_load accepted when key_load & key_ready
- subkey  out  [48:1]  PC-2(C,D) of the current round
- subkey_valid  out  1  subkey is valid for round `round`
- subkey_ready  in  1  round engine consumes subkey when subkey_valid & subkey_ready
- round  out  4  index of the subkey presented, 0..15 (output order, not key number)
- busy  out  1  high in GEN
- done  out  1  one-cycle pulse after the 16th subkey is consumed

## Operation
- Shift schedule: LS[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Total is 28, so C16D16 = C0D0.
- PC-1 and PC-2 follow FIPS 46-3 exactly, with bit 1 = MSB on all buses.
- C and D are 28-bit registers rotated independently.
- FSM states are IDLE and GEN.
- IDLE: key_ready=1, subkey_valid=0. On key_load:
  - Latch the mode bit.
  - Encrypt: load C,D = rotl(PC-1(key_in), LS[1]).
  - Decrypt: load C,D = PC-1(key_in).
  - Set round=0 and go to GEN.
- GEN: subkey_valid=1; subkey = PC-2(C,D), driven combinationally from the C/D registers only.
- Handshake in GEN (subkey_valid & subkey_ready):
  - If round<15: round += 1.
    - Encrypt: C,D = rotl(C,D, LS[round+2]), using the pre-increment round value.
    - Decrypt: C,D = rotr(C,D, LS[16−round]), using the pre-increment round value.
  - If round==15: go to IDLE, pulse done, round=0.
- Without a handshake, C, D, round and subkey hold unchanged. The ready-stall can be of any length.
- key_load while in GEN is ignored; a new key is only taken from IDLE.
- decrypt is sampled only at acceptance. Changes mid-schedule have no effect.
- rst at any cycle (including mid-GEN):
  - Go to IDLE with round=0, C=D=0, done=0, subkey_valid=0, key_ready=1, busy=0.
  - subkey = PC-2(0)=0.

## Timing
- Reset values: key_ready=1, busy=0, subkey_valid=0, done=0, round=0, subkey=0.
- Load latency: key_load accepted at edge N gives subkey_valid=1 and K1 (or K16) on subkey in the cycle after N.
- Throughput: with subkey_ready held high, one subkey per cycle. 16 consecutive valid cycles, then done=1 in the next cycle together with key_ready=1.
- A new key_load is accepted in the same cycle done is high. There is no dead cycle beyond that.
- subkey and round change only on a handshake edge or on load.
- When rst and key_load are high in the same cycle, rst wins.
- Rotations are modulo 28 per half. Bits never cross between C and D.

## Test plan
- Encrypt, key 0x133457799BBCDFF1, subkey_ready=1:
  - round 0 → 0x1B02EFFC7072
  - round 1 → 0x79AED9DBC9E5
  - round 15 → 0xCB3D8B0E17F5
  - done pulses one cycle after round 15.
- Decrypt, same key: round 0 → 0xCB3D8B0E17F5, round 15 → 0x1B02EFFC7072. All 16 subkeys equal the encrypt sequence reversed.
- Backpressure: subkey_ready toggled randomly. The subkey sequence is identical to the stall-free run, and subkey/round stay stable while valid & !ready.
- key_load pulsed mid-GEN with a different key: ignored, and the original sequence completes. Back-to-back load in the done cycle starts the new key on the next cycle.
- rst asserted at round 7 with ready stalled: next cycle all outputs are at reset values. A fresh load then produces the correct K1.
- Parity independence: keys differing only in bits 8,16,…,64 produce identical subkey streams.
